// File: rtl/tomasulo_pkg.sv
// Shared issue-stage types: opcode classes, illegal-opcode predicate and RAT entry.
package tomasulo_pkg;

  localparam int NCLS      = 3;
  // Widest ROB tag a RAT entry can hold (ROB_DEPTH up to 64).
  localparam int TAG_W_MAX = 6;

  typedef enum logic [1:0] {
    CLS_ADD = 2'b00,
    CLS_MUL = 2'b01,
    CLS_BCH = 2'b10
  } cls_e;

  typedef struct packed {
    logic                 busy;
    logic [TAG_W_MAX-1:0] tag;
  } rat_ent_t;

  function automatic logic is_illegal(input logic [3:0] f);
    return f[3];
  endfunction

  // 0000/0001 add, 0010/0011 mul, 01xx branch
  function automatic cls_e func_class(input logic [3:0] f);
    if (f[2]) return CLS_BCH;
    if (f[1]) return CLS_MUL;
    return CLS_ADD;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Issue-stage bus: decode input, release/commit/flush controls and dispatch output.
interface issue_ctrl_if #(
  parameter int NREG      = 16,
  parameter int ROB_DEPTH = 8,
  parameter int FUNC_W    = 4
);
  localparam int RW  = $clog2(NREG);
  localparam int TW  = $clog2(ROB_DEPTH);
  localparam int IDW = (RW > TW) ? RW : TW;

  logic              in_valid, in_ready;
  logic [FUNC_W-1:0] in_func;
  logic [RW-1:0]     in_rs1, in_rs2, in_rd;
  logic              rel_add, rel_mul, rel_bch;
  logic              commit_valid;
  logic [RW-1:0]     commit_rd;
  logic [TW-1:0]     commit_tag;
  logic              flush;
  logic              out_valid;
  logic [1:0]        out_class;
  logic [FUNC_W-1:0] out_func;
  logic [RW-1:0]     out_rd;
  logic [TW-1:0]     out_tag;
  logic              out_rs1_busy, out_rs2_busy;
  logic [IDW-1:0]    out_rs1_id, out_rs2_id;
  logic [TW:0]       rob_count;
  logic              illegal;

  modport master (
    output in_valid, in_func, in_rs1, in_rs2, in_rd, rel_add, rel_mul, rel_bch,
           commit_valid, commit_rd, commit_tag, flush,
    input  in_ready, out_valid, out_class, out_func, out_rd, out_tag,
           out_rs1_busy, out_rs2_busy, out_rs1_id, out_rs2_id, rob_count, illegal
  );

  modport slave (
    input  in_valid, in_func, in_rs1, in_rs2, in_rd, rel_add, rel_mul, rel_bch,
           commit_valid, commit_rd, commit_tag, flush,
    output in_ready, out_valid, out_class, out_func, out_rd, out_tag,
           out_rs1_busy, out_rs2_busy, out_rs1_id, out_rs2_id, rob_count, illegal
  );

endinterface

// File: rtl/rs_slot_counter.sv
// Occupancy counter for one reservation-station class; saturates at 0, reports full at LIMIT.
module rs_slot_counter #(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic full
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count_q, count_d;
  logic         dec_ok;

  assign dec_ok = dec && (count_q != '0);
  assign full   = (count_q >= LIM);

  always_comb begin
    count_d = count_q;
    if (clr)                 count_d = '0;
    else if (inc && !dec_ok) count_d = count_q + W'(1);
    else if (!inc && dec_ok) count_d = count_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else     count_q <= count_d;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue stage: ROB tag allocation, register rename table and per-class
// reservation-station admission, with registered dispatch to the stations.
module issue_ctrl
  import tomasulo_pkg::*;
#(
  parameter int NREG         = 16,
  parameter int ROB_DEPTH    = 8,
  parameter int RS_PER_CLASS = 3,
  parameter int FUNC_W       = 4
) (
  input logic         clk,
  input logic         rst,
  issue_ctrl_if.slave bus
);
  localparam int RW  = $clog2(NREG);
  localparam int TW  = $clog2(ROB_DEPTH);
  localparam int IDW = (RW > TW) ? RW : TW;
  localparam logic [TW:0] ROB_FULL = (TW+1)'(ROB_DEPTH);

  rat_ent_t [NREG-1:0] rat_q, rat_d;
  logic [TW-1:0]       tail_q, tail_d;
  logic [TW:0]         cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d, illegal_q, illegal_d;
  cls_e                out_cls_q, out_cls_d;
  logic [FUNC_W-1:0]   out_func_q, out_func_d;
  logic [RW-1:0]       out_rd_q, out_rd_d;
  logic [TW-1:0]       out_tag_q, out_tag_d;
  logic [IDW:0]        src1_q, src1_d, src2_q, src2_d;

  logic [NCLS-1:0]     cls_inc, cls_dec, cls_full;
  cls_e                cls;
  logic                ill, accept, alloc, cmt;

  // {busy, id}: a source whose producer retires this very cycle is already ready.
  function automatic logic [IDW:0] lookup(input rat_ent_t e, input logic [RW-1:0] s,
                                          input logic cv, input logic [RW-1:0] crd,
                                          input logic [TW-1:0] ctag);
    logic busy;
    busy = e.busy && !(cv && crd == s && e.tag == TAG_W_MAX'(ctag));
    return busy ? {1'b1, IDW'(e.tag[TW-1:0])} : {1'b0, IDW'(s)};
  endfunction

  assign ill          = is_illegal(bus.in_func[3:0]);
  assign cls          = func_class(bus.in_func[3:0]);
  assign bus.in_ready = !bus.flush && (cnt_q != ROB_FULL) && (ill || !cls_full[cls]);
  assign accept       = bus.in_valid && bus.in_ready;
  assign alloc        = accept && !ill;
  assign cmt          = bus.commit_valid && (cnt_q != '0) && !bus.flush;
  assign cls_dec      = {bus.rel_bch, bus.rel_mul, bus.rel_add};

  for (genvar c = 0; c < NCLS; c++) begin : g_cls
    assign cls_inc[c] = alloc && (cls == cls_e'(2'(c)));
    rs_slot_counter #(.LIMIT(RS_PER_CLASS)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.flush),
      .inc (cls_inc[c]),
      .dec (cls_dec[c]),
      .full(cls_full[c])
    );
  end

  always_comb begin
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    rat_d       = rat_q;
    out_valid_d = alloc;
    illegal_d   = accept && ill;
    out_cls_d   = out_cls_q;
    out_func_d  = out_func_q;
    out_rd_d    = out_rd_q;
    out_tag_d   = out_tag_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    if (alloc) begin
      tail_d     = tail_q + TW'(1);
      out_cls_d  = cls;
      out_func_d = bus.in_func;
      out_rd_d   = bus.in_rd;
      out_tag_d  = tail_q;
      src1_d     = lookup(rat_q[bus.in_rs1], bus.in_rs1, bus.commit_valid, bus.commit_rd, bus.commit_tag);
      src2_d     = lookup(rat_q[bus.in_rs2], bus.in_rs2, bus.commit_valid, bus.commit_rd, bus.commit_tag);
    end
    if (alloc && !cmt)      cnt_d = cnt_q + (TW+1)'(1);
    else if (!alloc && cmt) cnt_d = cnt_q - (TW+1)'(1);
    // Commit clears first so a same-cycle rename of the same register wins.
    for (int i = 0; i < NREG; i++) begin
      if (cmt && bus.commit_rd == RW'(i) && rat_q[i].tag == TAG_W_MAX'(bus.commit_tag))
        rat_d[i].busy = 1'b0;
      if (alloc && bus.in_rd == RW'(i))
        rat_d[i] = '{busy: 1'b1, tag: TAG_W_MAX'(tail_q)};
    end
    if (bus.flush) begin
      rat_d  = '0;
      cnt_d  = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rat_q       <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      out_cls_q   <= CLS_ADD;
      out_func_q  <= '0;
      out_rd_q    <= '0;
      out_tag_q   <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
    end else begin
      rat_q       <= rat_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      out_cls_q   <= out_cls_d;
      out_func_q  <= out_func_d;
      out_rd_q    <= out_rd_d;
      out_tag_q   <= out_tag_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
    end

  assign bus.out_valid    = out_valid_q;
  assign bus.illegal      = illegal_q;
  assign bus.out_class    = out_cls_q;
  assign bus.out_func     = out_func_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_tag      = out_tag_q;
  assign bus.out_rs1_busy = src1_q[IDW];
  assign bus.out_rs1_id   = src1_q[IDW-1:0];
  assign bus.out_rs2_busy = src2_q[IDW];
  assign bus.out_rs2_id   = src2_q[IDW-1:0];
  assign bus.rob_count    = cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Table-driven bench for issue_ctrl: expected dispatches queued at drive time,
// popped and compared when out_valid appears; hand sequences for flush and reset.
module tb_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_ctrl_if #(.NREG(16), .ROB_DEPTH(8), .FUNC_W(4)) bus ();

  issue_ctrl #(.NREG(16), .ROB_DEPTH(8), .RS_PER_CLASS(3), .FUNC_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       vld;
    logic [3:0] func, rs1, rs2, rd;
    logic       cv;
    logic [3:0] crd;
    logic [2:0] ctag;
    logic [2:0] rel;
    logic       fl;
    logic       e_rdy, e_ill;
    logic [1:0] e_cls;
    logic [2:0] e_tag;
    logic       e_b1;
    logic [3:0] e_id1;
    logic       e_b2;
    logic [3:0] e_id2;
    logic [3:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [1:0] cls;
    logic [2:0] tag;
    logic [3:0] rd, func;
    logic       b1;
    logic [3:0] id1;
    logic       b2;
    logic [3:0] id2;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(int vld, int func, int rs1, int rs2, int rd,
                              int cv, int crd, int ctag, int rel, int fl,
                              int rdy, int ill, int cls, int tag,
                              int b1, int id1, int b2, int id2, int cnt);
    vec_t v;
    v.vld = 1'(vld);   v.func = 4'(func); v.rs1 = 4'(rs1); v.rs2 = 4'(rs2); v.rd = 4'(rd);
    v.cv = 1'(cv);     v.crd = 4'(crd);   v.ctag = 3'(ctag); v.rel = 3'(rel); v.fl = 1'(fl);
    v.e_rdy = 1'(rdy); v.e_ill = 1'(ill); v.e_cls = 2'(cls); v.e_tag = 3'(tag);
    v.e_b1 = 1'(b1);   v.e_id1 = 4'(id1); v.e_b2 = 1'(b2);   v.e_id2 = 4'(id2); v.e_cnt = 4'(cnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_func = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    bus.rel_add = 1'b0; bus.rel_mul = 1'b0; bus.rel_bch = 1'b0;
    bus.commit_valid = 1'b0; bus.commit_rd = '0; bus.commit_tag = '0; bus.flush = 1'b0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic apply(input vec_t v);
    exp_t e;
    bus.in_valid = v.vld; bus.in_func = v.func; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2; bus.in_rd = v.rd;
    bus.commit_valid = v.cv; bus.commit_rd = v.crd; bus.commit_tag = v.ctag;
    bus.rel_add = v.rel[0]; bus.rel_mul = v.rel[1]; bus.rel_bch = v.rel[2]; bus.flush = v.fl;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(v.e_rdy));
    if (v.vld && v.e_rdy && !v.func[3]) begin
      e.cls = v.e_cls; e.tag = v.e_tag; e.rd = v.rd; e.func = v.func;
      e.b1 = v.e_b1; e.id1 = v.e_id1; e.b2 = v.e_b2; e.id2 = v.e_id2;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    idle();
    chk("out_valid", 32'(bus.out_valid), 32'(sbq.size() != 0));
    if (bus.out_valid && sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("out_class", 32'(bus.out_class), 32'(e.cls));
      chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
      chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
      chk("out_func", 32'(bus.out_func), 32'(e.func));
      chk("rs1_busy", 32'(bus.out_rs1_busy), 32'(e.b1));
      chk("rs1_id", 32'(bus.out_rs1_id), 32'(e.id1));
      chk("rs2_busy", 32'(bus.out_rs2_busy), 32'(e.b2));
      chk("rs2_id", 32'(bus.out_rs2_id), 32'(e.id2));
    end
    sbq.delete();
    chk("illegal", 32'(bus.illegal), 32'(v.e_ill));
    chk("rob_count", 32'(bus.rob_count), 32'(v.e_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t tbl[18];

  initial begin
    //           vld func    rs1 rs2 rd cv crd ct rel fl rdy ill cls tag b1 id1 b2 id2 cnt
    tbl[0]  = mk(1, 'b0000,  1,  2,  3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 1);
    tbl[1]  = mk(1, 'b0010,  3,  3,  4, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 1, 0, 2);
    tbl[2]  = mk(1, 'b0011,  3,  3,  6, 1, 3, 0, 0, 0, 1, 0, 1, 2, 0, 3, 0, 3, 2);
    tbl[3]  = mk(1, 'b0001,  4,  0,  5, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1, 1, 0, 0, 3);
    tbl[4]  = mk(1, 'b0000,  5,  6,  5, 0, 0, 0, 0, 0, 1, 0, 0, 4, 1, 3, 1, 2, 4);
    tbl[5]  = mk(1, 'b0000,  1,  1,  7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    tbl[6]  = mk(1, 'b0000,  1,  1,  7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    tbl[7]  = mk(1, 'b0000,  1,  1,  7, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 1, 0, 1, 5);
    tbl[8]  = mk(1, 'b0100,  2,  7,  8, 0, 0, 0, 0, 0, 1, 0, 2, 6, 0, 2, 1, 5, 6);
    tbl[9]  = mk(1, 'b1010,  0,  0,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 6);
    tbl[10] = mk(1, 'b0111,  9,  5,  9, 0, 0, 0, 0, 0, 1, 0, 2, 7, 0, 9, 1, 4, 7);
    tbl[11] = mk(1, 'b0010,  6,  4, 10, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 2, 1, 1, 8);
    tbl[12] = mk(1, 'b0101,  4,  0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    tbl[13] = mk(1, 'b0101,  4,  0, 11, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    tbl[14] = mk(1, 'b0101,  4,  0, 11, 1, 6, 2, 0, 0, 1, 0, 2, 1, 0, 4, 0, 0, 7);
    tbl[15] = mk(0, 'b0010,  0,  0,  0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    tbl[16] = mk(1, 'b0010,  6,  5, 12, 0, 0, 0, 2, 0, 1, 0, 1, 2, 0, 6, 1, 4, 8);
    tbl[17] = mk(1, 'b0011,  0,  0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);

    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst rob_count", 32'(bus.rob_count), 32'd0);
    chk("rst illegal", 32'(bus.illegal), 32'd0);
    rst = 1'b0;
    #1 chk("rel in_ready", 32'(bus.in_ready), 32'd1);

    foreach (tbl[i]) apply(tbl[i]);

    // Two writers to r5, older one retires, then flush discards everything.
    do_reset();
    apply(mk(1, 'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(1, 'b0001, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2));
    apply(mk(1, 'b0010, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0, 3));
    apply(mk(0, 'b0000, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
    apply(mk(0, 'b0000, 0, 0, 0, 1, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(1, 'b0100, 5, 1, 2, 0, 0, 0, 0, 0, 1, 0, 2, 3, 1, 2, 0, 1, 2));
    apply(mk(1, 'b0000, 5, 5, 6, 1, 5, 2, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 'b0000, 5, 2, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5, 0, 2, 1));
    apply(mk(1, 'b0001, 0, 0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2));

    // Illegal opcode, then an issue, then asynchronous reset between edges.
    apply(mk(1, 'b1010, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2));
    apply(mk(1, 'b0011, 8, 0, 9, 0, 0, 0, 0, 0, 1, 0, 1, 2, 1, 1, 0, 0, 3));
    #2 rst = 1'b1;
    #1;
    chk("async out_valid", 32'(bus.out_valid), 32'd0);
    chk("async out_tag", 32'(bus.out_tag), 32'd0);
    chk("async out_rd", 32'(bus.out_rd), 32'd0);
    chk("async out_class", 32'(bus.out_class), 32'd0);
    chk("async out_func", 32'(bus.out_func), 32'd0);
    chk("async rs1_busy", 32'(bus.out_rs1_busy), 32'd0);
    chk("async rs1_id", 32'(bus.out_rs1_id), 32'd0);
    chk("async rob_count", 32'(bus.rob_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);
    apply(mk(1, 'b0000, 8, 9, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8, 0, 9, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
